// File: rtl/pgm_rd.sv
// pgm_rd: read/transmit side of the packet generator.
// Forwards bypass packets and replays the RAM template with a fixed gap.
module pgm_rd #(
   parameter        PLATFORM   = "Xilinx",
   parameter [7:0]  LMID       = 8'd63,
   parameter [15:0] GAP_CYCLES = 16'd12,
   parameter [6:0]  MAX_ADDR   = 7'd127
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [1023:0] in_rd_phv,
   input  logic          in_rd_phv_wr,
   output logic          out_rd_phv_alf,
   input  logic [133:0]  in_rd_data,
   input  logic          in_rd_data_wr,
   input  logic          in_rd_valid,
   input  logic          in_rd_valid_wr,
   output logic          out_rd_alf,
   input  logic          pgm_bypass_flag,
   input  logic          pgm_sent_start_flag,
   input  logic          pgm_sent_finish_flag,
   output logic          rd2ram_rd_en,
   output logic [6:0]    rd2ram_addr,
   input  logic [143:0]  ram2rd_rdata,
   output logic [1023:0] out_rd_phv,
   output logic          out_rd_phv_wr,
   input  logic          in_rd_phv_alf,
   output logic [133:0]  out_rd_data,
   output logic          out_rd_data_wr,
   output logic          out_rd_valid,
   output logic          out_rd_valid_wr,
   input  logic          in_rd_alf,
   output logic [31:0]   gen_pkt_cnt,
   output logic [31:0]   drop_word_cnt
);

   typedef enum logic [1:0] {IDLE, BYPASS, READ, GAP} state_t;

   state_t          state_q, state_d;
   logic            start_q, finish_q;
   logic            armed_q, armed_d;
   logic            stop_q, stop_d;
   logic            rd_en_q, rd_en_d;
   logic [6:0]      rd_addr_q, rd_addr_d;
   logic            pend_q;
   logic [6:0]      pend_addr_q;
   logic [15:0]     gap_cnt_q, gap_cnt_d;
   logic [133:0]    data_q, data_d;
   logic            data_wr_q, data_wr_d;
   logic [1023:0]   phv_q, phv_d;
   logic            phv_wr_q, phv_wr_d;
   logic            valid_q, valid_d;
   logic            valid_wr_q, valid_wr_d;
   logic [31:0]     gen_q, gen_d;
   logic [31:0]     drop_q, drop_d;

   logic            start_edge, finish_edge;
   logic            in_head, in_tail;
   logic [1:0]      ram_tag;
   logic            ram_tail, gap_done, alf_any;
   logic            unused_ok;

   assign out_rd_alf     = in_rd_alf;
   assign out_rd_phv_alf = in_rd_phv_alf;

   assign start_edge  = pgm_sent_start_flag & ~start_q;
   assign finish_edge = pgm_sent_finish_flag & ~finish_q;
   assign in_head  = in_rd_data_wr & (in_rd_data[133:132] == 2'b01);
   assign in_tail  = in_rd_data_wr & (in_rd_data[133:132] == 2'b10);
   assign ram_tag  = ram2rd_rdata[133:132];
   assign ram_tail = (ram_tag == 2'b10) | (pend_addr_q == MAX_ADDR);
   assign gap_done = (gap_cnt_q == GAP_CYCLES);
   assign alf_any  = in_rd_alf | in_rd_phv_alf;

   assign unused_ok = ^{ram2rd_rdata[143:134], LMID, pgm_bypass_flag,
                        (PLATFORM == "Xilinx")};

   // Next state, RAM read sequencing, output word selection and counters
   always_comb begin
      state_d    = state_q;
      armed_d    = armed_q;
      stop_d     = stop_q;
      rd_en_d    = 1'b0;
      rd_addr_d  = rd_addr_q;
      gap_cnt_d  = gap_cnt_q;
      data_d     = '0;
      data_wr_d  = 1'b0;
      phv_d      = '0;
      phv_wr_d   = 1'b0;
      valid_d    = 1'b0;
      valid_wr_d = 1'b0;
      gen_d      = gen_q;
      drop_d     = drop_q;

      if (state_q == BYPASS || (state_q == IDLE && in_head)) begin
         data_d     = in_rd_data_wr ? in_rd_data : '0;
         data_wr_d  = in_rd_data_wr;
         phv_d      = in_rd_phv_wr ? in_rd_phv : '0;
         phv_wr_d   = in_rd_phv_wr;
         valid_d    = in_rd_valid & in_rd_valid_wr;
         valid_wr_d = in_rd_valid_wr;
      end

      case (state_q)
         IDLE: begin
            if (in_head) begin
               state_d = BYPASS;
            end else if (armed_q && !alf_any) begin
               rd_en_d   = 1'b1;
               rd_addr_d = '0;
               state_d   = READ;
            end
         end
         BYPASS: begin
            if (in_tail) state_d = IDLE;
         end
         READ: begin
            if (in_rd_data_wr) drop_d = drop_q + 32'd1;
            if (pend_q) begin
               data_d    = ram2rd_rdata[133:0];
               data_wr_d = 1'b1;
               if (ram_tag == 2'b01) phv_wr_d = 1'b1;
            end
            if (pend_q && ram_tail) begin
               data_d[133:132] = 2'b10;
               valid_d    = 1'b1;
               valid_wr_d = 1'b1;
               gen_d      = gen_q + 32'd1;
               gap_cnt_d  = '0;
               state_d    = GAP;
            end else if (rd_en_q && rd_addr_q != MAX_ADDR) begin
               rd_en_d   = 1'b1;
               rd_addr_d = rd_addr_q + 7'd1;
            end
         end
         GAP: begin
            if (in_rd_data_wr) drop_d = drop_q + 32'd1;
            if (!gap_done) begin
               gap_cnt_d = gap_cnt_q + 16'd1;
            end else if (stop_q) begin
               armed_d = 1'b0;
               stop_d  = 1'b0;
               state_d = IDLE;
            end else if (!alf_any) begin
               rd_en_d   = 1'b1;
               rd_addr_d = '0;
               state_d   = READ;
            end
         end
         default: state_d = IDLE;
      endcase

      if (start_edge) begin
         armed_d = 1'b1;
         stop_d  = 1'b0;
      end else if (finish_edge) begin
         stop_d = 1'b1;
      end
   end

   // State, pipeline and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         start_q     <= 1'b0;
         finish_q    <= 1'b0;
         armed_q     <= 1'b0;
         stop_q      <= 1'b0;
         rd_en_q     <= 1'b0;
         rd_addr_q   <= '0;
         pend_q      <= 1'b0;
         pend_addr_q <= '0;
         gap_cnt_q   <= '0;
         data_q      <= '0;
         data_wr_q   <= 1'b0;
         phv_q       <= '0;
         phv_wr_q    <= 1'b0;
         valid_q     <= 1'b0;
         valid_wr_q  <= 1'b0;
         gen_q       <= '0;
         drop_q      <= '0;
      end else begin
         state_q     <= state_d;
         start_q     <= pgm_sent_start_flag;
         finish_q    <= pgm_sent_finish_flag;
         armed_q     <= armed_d;
         stop_q      <= stop_d;
         rd_en_q     <= rd_en_d;
         rd_addr_q   <= rd_addr_d;
         pend_q      <= rd_en_q;
         pend_addr_q <= rd_addr_q;
         gap_cnt_q   <= gap_cnt_d;
         data_q      <= data_d;
         data_wr_q   <= data_wr_d;
         phv_q       <= phv_d;
         phv_wr_q    <= phv_wr_d;
         valid_q     <= valid_d;
         valid_wr_q  <= valid_wr_d;
         gen_q       <= gen_d;
         drop_q      <= drop_d;
      end
   end

   assign rd2ram_rd_en    = rd_en_q;
   assign rd2ram_addr     = rd_addr_q;
   assign out_rd_data     = data_q;
   assign out_rd_data_wr  = data_wr_q;
   assign out_rd_phv      = phv_q;
   assign out_rd_phv_wr   = phv_wr_q;
   assign out_rd_valid    = valid_q;
   assign out_rd_valid_wr = valid_wr_q;
   assign gen_pkt_cnt     = gen_q;
   assign drop_word_cnt   = drop_q;

endmodule

// File: tb/tb_pgm_rd.sv
// tb_pgm_rd: directed/randomized bench for pgm_rd.
// Output words are captured by a monitor and checked against a packet model.
module tb_pgm_rd;

   logic          clk, rst_n;
   logic [1023:0] in_rd_phv;
   logic          in_rd_phv_wr, out_rd_phv_alf;
   logic [133:0]  in_rd_data;
   logic          in_rd_data_wr, in_rd_valid, in_rd_valid_wr, out_rd_alf;
   logic          pgm_bypass_flag, pgm_sent_start_flag, pgm_sent_finish_flag;
   logic          rd2ram_rd_en;
   logic [6:0]    rd2ram_addr;
   logic [143:0]  ram2rd_rdata;
   logic [1023:0] out_rd_phv;
   logic          out_rd_phv_wr, in_rd_phv_alf;
   logic [133:0]  out_rd_data;
   logic          out_rd_data_wr, out_rd_valid, out_rd_valid_wr, in_rd_alf;
   logic [31:0]   gen_pkt_cnt, drop_word_cnt;

   pgm_rd dut (
      .clk(clk), .rst_n(rst_n),
      .in_rd_phv(in_rd_phv), .in_rd_phv_wr(in_rd_phv_wr),
      .out_rd_phv_alf(out_rd_phv_alf),
      .in_rd_data(in_rd_data), .in_rd_data_wr(in_rd_data_wr),
      .in_rd_valid(in_rd_valid), .in_rd_valid_wr(in_rd_valid_wr),
      .out_rd_alf(out_rd_alf),
      .pgm_bypass_flag(pgm_bypass_flag),
      .pgm_sent_start_flag(pgm_sent_start_flag),
      .pgm_sent_finish_flag(pgm_sent_finish_flag),
      .rd2ram_rd_en(rd2ram_rd_en), .rd2ram_addr(rd2ram_addr),
      .ram2rd_rdata(ram2rd_rdata),
      .out_rd_phv(out_rd_phv), .out_rd_phv_wr(out_rd_phv_wr),
      .in_rd_phv_alf(in_rd_phv_alf),
      .out_rd_data(out_rd_data), .out_rd_data_wr(out_rd_data_wr),
      .out_rd_valid(out_rd_valid), .out_rd_valid_wr(out_rd_valid_wr),
      .in_rd_alf(in_rd_alf),
      .gen_pkt_cnt(gen_pkt_cnt), .drop_word_cnt(drop_word_cnt)
   );

   typedef struct {
      int            cyc;
      logic [133:0]  d;
      logic          phv_wr;
      logic [1023:0] phv;
      logic          valid_wr;
      logic          valid;
   } ev_t;

   ev_t          q[$];
   logic [133:0] mem[128];
   logic [133:0] exp_pkt[$];
   int           cyc = 0;
   int           tests = 0;
   int           fails = 0;
   int           exp_gen = 0;

   initial begin
      clk = 0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   // Synchronous-read RAM model: data one cycle after the read enable
   always @(posedge clk)
      if (rd2ram_rd_en) ram2rd_rdata <= {10'h2a5, mem[rd2ram_addr]};

   // Output monitor, sampled away from the active edge
   always @(negedge clk)
      if (rst_n && out_rd_data_wr)
         q.push_back('{cyc, out_rd_data, out_rd_phv_wr, out_rd_phv,
                       out_rd_valid_wr, out_rd_valid});

   task automatic chk(input string tag, input logic [1023:0] obs,
                      input logic [1023:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   function automatic logic [131:0] rnd132();
      logic [131:0] r;
      r = {$urandom(), $urandom(), $urandom(), $urandom(), 4'h0};
      r[3:0] = 4'($urandom());
      return r;
   endfunction

   task automatic load_mem(input int len, input bit with_tail);
      for (int a = 0; a < 128; a++) mem[a] = {2'b11, rnd132()};
      mem[0][133:132] = 2'b01;
      if (with_tail) mem[len-1][133:132] = 2'b10;
   endtask

   // Template as transmitted: words up to the first tail, tail forced at top
   task automatic build_exp();
      logic [133:0] w;
      exp_pkt.delete();
      for (int a = 0; a < 128; a++) begin
         w = mem[a];
         if (a == 127) w[133:132] = 2'b10;
         exp_pkt.push_back(w);
         if (w[133:132] == 2'b10) break;
      end
   endtask

   task automatic wait_gen(input int target, input int budget);
      int n = 0;
      while (int'(gen_pkt_cnt) < target && n < budget) begin
         tick(1);
         n++;
      end
      chk("wait_gen", gen_pkt_cnt, target);
   endtask

   task automatic wait_q(input int n, input int budget);
      int k = 0;
      while (q.size() < n && k < budget) begin
         tick(1);
         k++;
      end
      chk("wait_q", q.size() >= n, 1);
   endtask

   task automatic check_gen(input int npkts, input bit chk_gap);
      ev_t e;
      int  first, prev_tail;
      int  len;
      len = exp_pkt.size();
      prev_tail = 0;
      chk("gen_qsize", q.size(), npkts * len);
      for (int p = 0; p < npkts && q.size() >= len; p++) begin
         first = q[0].cyc;
         if (chk_gap && p > 0) chk("gen_gap", first - prev_tail, 15);
         for (int i = 0; i < len; i++) begin
            e = q.pop_front();
            chk("gen_data", e.d, exp_pkt[i]);
            chk("gen_contig", e.cyc, first + i);
            chk("gen_phv_wr", e.phv_wr, i == 0);
            chk("gen_valid_wr", e.valid_wr, i == len - 1);
            if (i == 0) chk("gen_phv_zero", e.phv, 0);
            prev_tail = e.cyc;
         end
      end
   endtask

   task automatic bypass_pkt(input int len);
      int            s;
      ev_t           e;
      logic [133:0]  w[$];
      logic [1023:0] phv;
      q.delete();
      phv = {32{$urandom()}};
      s = cyc;
      for (int i = 0; i < len; i++) begin
         w.push_back({(i == 0) ? 2'b01 : (i == len - 1) ? 2'b10 : 2'b11,
                      rnd132()});
         in_rd_data     = w[i];
         in_rd_data_wr  = 1'b1;
         in_rd_phv      = phv;
         in_rd_phv_wr   = (i == 0);
         in_rd_valid    = (i == len - 1);
         in_rd_valid_wr = (i == len - 1);
         tick(1);
      end
      in_rd_data_wr  = 0;
      in_rd_phv_wr   = 0;
      in_rd_valid    = 0;
      in_rd_valid_wr = 0;
      in_rd_data     = '0;
      tick(4);
      chk("byp_count", q.size(), len);
      for (int i = 0; i < len && q.size() > 0; i++) begin
         e = q.pop_front();
         chk("byp_data", e.d, w[i]);
         chk("byp_cyc", e.cyc, s + 1 + i);
         chk("byp_valid_wr", e.valid_wr, i == len - 1);
         if (i == len - 1) chk("byp_valid", e.valid, 1);
         if (i == 0) chk("byp_phv", e.phv, phv);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      int n, d, len, hold;
      rst_n = 0;
      in_rd_phv = '0; in_rd_phv_wr = 0;
      in_rd_data = '0; in_rd_data_wr = 0;
      in_rd_valid = 0; in_rd_valid_wr = 0;
      pgm_bypass_flag = 0;
      pgm_sent_start_flag = 0; pgm_sent_finish_flag = 0;
      in_rd_phv_alf = 0; in_rd_alf = 0;
      ram2rd_rdata = '0;
      for (int a = 0; a < 128; a++) mem[a] = '0;
      tick(3);
      chk("rst_data_wr", out_rd_data_wr, 0);
      chk("rst_data", out_rd_data, 0);
      chk("rst_rd_en", rd2ram_rd_en, 0);
      chk("rst_gen", gen_pkt_cnt, 0);
      chk("rst_drop", drop_word_cnt, 0);
      rst_n = 1;
      tick(2);

      in_rd_alf = 1; #1;
      chk("alf_pass", out_rd_alf, 1);
      in_rd_phv_alf = 1; #1;
      chk("phv_alf_pass", out_rd_phv_alf, 1);
      in_rd_alf = 0; in_rd_phv_alf = 0; #1;
      chk("alf_pass_lo", {out_rd_alf, out_rd_phv_alf}, 0);
      tick(1);

      // Bypass
      bypass_pkt(3);
      bypass_pkt($urandom_range(6, 2));
      chk("byp_gen", gen_pkt_cnt, 0);

      // Generation, then finish raised on word 2 of packet 3
      load_mem(4, 1);
      build_exp();
      q.delete();
      pgm_sent_start_flag = 1;
      wait_gen(2, 200);
      wait_q(10, 100);
      pgm_sent_finish_flag = 1;
      tick(80);
      exp_gen = 3;
      chk("fin_gen", gen_pkt_cnt, exp_gen);
      check_gen(3, 1);
      n = 0;
      for (int i = 0; i < 40; i++) begin
         if (rd2ram_rd_en) n++;
         tick(1);
      end
      chk("fin_idle_reads", n, 0);

      // Backpressure in GAP and mid-packet
      pgm_sent_finish_flag = 0;
      pgm_sent_start_flag = 0;
      tick(2);
      len = $urandom_range(6, 3);
      load_mem(len, 1);
      build_exp();
      q.delete();
      pgm_sent_start_flag = 1;
      wait_gen(exp_gen + 1, 300);
      in_rd_alf = 1;
      hold = $urandom_range(40, 20);
      tick(hold);
      chk("bp_hold", q.size(), len);
      d = cyc;
      in_rd_alf = 0;
      wait_q(len + 1, 50);
      if (q.size() > len) chk("bp_head_cyc", q[len].cyc, d + 3);
      in_rd_alf = 1;
      wait_gen(exp_gen + 2, 100);
      pgm_sent_finish_flag = 1;
      in_rd_alf = 0;
      tick(40);
      exp_gen += 2;
      chk("bp_gen", gen_pkt_cnt, exp_gen);
      check_gen(2, 0);

      // Missing tail: 128 words, last forced to tail
      pgm_sent_finish_flag = 0;
      pgm_sent_start_flag = 0;
      tick(2);
      load_mem(0, 0);
      build_exp();
      chk("nt_model_len", exp_pkt.size(), 128);
      q.delete();
      pgm_sent_start_flag = 1;
      wait_gen(exp_gen + 1, 400);
      pgm_sent_finish_flag = 1;
      tick(40);
      exp_gen += 1;
      chk("nt_gen", gen_pkt_cnt, exp_gen);
      check_gen(1, 0);

      // Reset mid-read, then re-arm and inject a word in GAP
      pgm_sent_finish_flag = 0;
      pgm_sent_start_flag = 0;
      tick(2);
      load_mem(4, 1);
      build_exp();
      q.delete();
      pgm_sent_start_flag = 1;
      wait_q(2, 100);
      #2;
      rst_n = 0;
      #1;
      chk("arst_data_wr", out_rd_data_wr, 0);
      chk("arst_data", out_rd_data, 0);
      chk("arst_rd_en", rd2ram_rd_en, 0);
      chk("arst_valid_wr", out_rd_valid_wr, 0);
      chk("arst_gen", gen_pkt_cnt, 0);
      chk("arst_drop", drop_word_cnt, 0);
      pgm_sent_start_flag = 0;
      tick(2);
      rst_n = 1;
      q.delete();
      tick(2);
      pgm_sent_start_flag = 1;
      wait_gen(1, 200);
      tick(3);
      in_rd_data = {2'b11, rnd132()};
      in_rd_data_wr = 1;
      tick(1);
      in_rd_data_wr = 0;
      in_rd_data = '0;
      wait_gen(3, 200);
      pgm_sent_finish_flag = 1;
      tick(60);
      chk("drop_cnt", drop_word_cnt, 1);
      chk("drop_gen", gen_pkt_cnt, 3);
      check_gen(3, 1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/pgm_rd.md
Name: pgm_rd

Overview:
- Read and transmit side of the packet generator module (PGM).
- Forwards bypass packets handed over by the PGM write stage unchanged.
- When the write stage signals that a template packet is stored in PGM_RAM, reads the template back word by word and transmits it repeatedly to the next module, with a fixed inter-packet gap, until the write stage signals finish.
- Keeps a generated-packet counter and a dropped-word counter for software visibility.

Parameters:
- PLATFORM, "Xilinx", target vendor selector.
- LMID, 8'd63, module ID of this block.
- GAP_CYCLES, 16'd12, idle cycles between the end of one generated packet and the start of the next.
- MAX_ADDR, 7'd127, highest PGM_RAM address.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- in_rd_phv  in  1024  PHV from write stage
- in_rd_phv_wr  in  1  PHV strobe
- out_rd_phv_alf  out  1  almost-full to write stage
- in_rd_data  in  134  packet word; [133:132] 01=head, 11=body, 10=tail
- in_rd_data_wr  in  1  data strobe
- in_rd_valid  in  1  packet-valid flag
- in_rd_valid_wr  in  1  valid strobe
- out_rd_alf  out  1  data almost-full to write stage
- pgm_bypass_flag  in  1  write stage is bypassing
- pgm_sent_start_flag  in  1  template stored (level)
- pgm_sent_finish_flag  in  1  stop generation (level)
- rd2ram_rd_en  out  1  RAM read enable
- rd2ram_addr  out  7  RAM read address
- ram2rd_rdata  in  144  RAM read data, valid 1 cycle after rd_en; packet word in [133:0]
- out_rd_phv  out  1024  PHV to next module
- out_rd_phv_wr  out  1  PHV strobe
- in_rd_phv_alf  in  1  PHV almost-full from next module
- out_rd_data  out  134  packet word to next module
- out_rd_data_wr  out  1  data strobe
- out_rd_valid  out  1  packet-valid flag
- out_rd_valid_wr  out  1  valid strobe
- in_rd_alf  in  1  data almost-full from next module
- gen_pkt_cnt  out  32  generated packets sent
- drop_word_cnt  out  32  input words dropped

Behaviour:
- **Reset:** asynchronous, on rst_n low. All outputs and both counters go to 0, state goes to IDLE.
- **Almost-full passthrough:** out_rd_alf = in_rd_alf and out_rd_phv_alf = in_rd_phv_alf, combinationally.
- **Edge detection:**
  - Registered rising-edge detectors on pgm_sent_start_flag and pgm_sent_finish_flag.
  - A start edge sets armed=1 and clears stop_req.
  - A finish edge sets stop_req=1.
  - If both edges occur in the same cycle, start wins.
- **IDLE:**
  - A head word on the input (in_rd_data_wr=1, [133:132]=01) moves to BYPASS and is forwarded at 1-cycle latency.
  - Otherwise, if armed, in_rd_alf=0 and in_rd_phv_alf=0, issue rd_en with addr=0 and move to READ.
- **BYPASS:**
  - Every input word is registered to the output after 1 cycle, with the data, phv and valid fields and strobes copied.
  - The tail word returns the state to IDLE.
- **READ:**
  - Issue rd_en with an incrementing address every cycle.
  - Each returned RAM word is driven on out_rd_data[133:0] with out_rd_data_wr=1.
  - Latency from rd_en to out_rd_data_wr is 2 cycles: 1 RAM cycle plus 1 output register.
  - Head word: out_rd_phv=0 and out_rd_phv_wr=1.
  - Tail word (returned [133:132]=10):
    - drive out_rd_valid=1 and out_rd_valid_wr=1;
    - increment gen_pkt_cnt, wrapping at 2^32;
    - stop issuing reads; one speculative read past the tail is allowed, and its data is ignored;
    - move to GAP.
  - If address MAX_ADDR is reached without a tail, the word read at MAX_ADDR is output with [133:132] forced to 10 and treated as the tail.
  - in_rd_alf is ignored mid-packet; it is checked only at packet boundaries.
- **GAP:**
  - Count GAP_CYCLES cycles.
  - Then: if stop_req, clear armed and go to IDLE; otherwise, if both almost-fulls are low, restart READ at addr 0; otherwise hold in GAP.
- **Finish timing:** a finish edge mid-packet never truncates the packet; the stop takes effect at the next GAP exit.
- **Dropped input:** an input data word arriving in READ or GAP is dropped and drop_word_cnt is incremented. The write stage guarantees no bypass traffic during generation, so this case is an error indicator only.
- **Strobe defaults:** all output strobes are 0 in any cycle without a transfer. Data fields are zeroed when not written.

Test Plan:
- **Bypass:** 3-word packet (01, 11, 10) with in_rd_valid=1 -> identical 3 words on out_rd_data 1 cycle later; out_rd_valid_wr=1 on the tail; gen_pkt_cnt=0.
- **Generation:** RAM preloaded with 4 words (addr 3 has [133:132]=10), start flag raised, GAP_CYCLES=12 -> 4-word packets repeat; head of packet N+1 appears exactly 12 idle cycles plus read latency after the tail of packet N; gen_pkt_cnt increments per tail.
- **Finish mid-packet:** finish edge during word 2 -> packet completes all 4 words, no further packets, armed=0, state IDLE.
- **Backpressure:** in_rd_alf=1 during GAP -> no new head until alf drops; alf raised mid-packet -> packet still completes contiguously.
- **Missing tail:** no tail in RAM -> 128 words output, last word has [133:132]=10, gen_pkt_cnt=1.
- **Reset and drop:** rst_n low during READ -> all outputs 0 immediately and counters 0. After re-arming, an input word injected during GAP -> drop_word_cnt=1 and generated packets are unaffected.
